// File: rtl/thermostat_pkg.sv
// rtl/thermostat_pkg.sv - shared HVAC state encodings, mode codes and helpers
package thermostat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEAT    = 3'd1,
    ST_COOL    = 3'd2,
    ST_FAN_RUN = 3'd3,
    ST_REST    = 3'd4
  } hvac_state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_HEAT = 2'b01;
  localparam logic [1:0] MODE_COOL = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  // Seconds timers; wide enough for multi-minute rest periods.
  localparam int TIMER_W = 16;

  function automatic logic heat_allowed(input logic [1:0] mode);
    return (mode == MODE_HEAT) || (mode == MODE_AUTO);
  endfunction

  function automatic logic cool_allowed(input logic [1:0] mode);
    return (mode == MODE_COOL) || (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - one-cycle pulse every g_clk_freq clocks
module sec_tick_gen #(
  parameter int g_clk_freq = 20000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int CNT_W = (g_clk_freq > 1) ? $clog2(g_clk_freq) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(g_clk_freq - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == CNT_MAX);

endmodule

// File: rtl/hvac_controller.sv
// rtl/hvac_controller.sv - thermostat FSM with min on/off times, fan overrun
// and stale-temperature shutdown.
module hvac_controller
  import thermostat_pkg::*;
#(
  parameter int g_clk_freq  = 20000,
  parameter int g_hyst      = 4,
  parameter int g_min_on_s  = 120,
  parameter int g_min_off_s = 300,
  parameter int g_fan_run_s = 60,
  parameter int g_stale_s   = 30
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sys_pwr_n,
  input  logic [1:0] i_mode,
  input  logic [9:0] i_temp,
  input  logic       i_temp_valid,
  input  logic [9:0] i_setpoint,
  output logic       o_heat,
  output logic       o_cool,
  output logic       o_fan,
  output logic [2:0] o_state,
  output logic       o_fault
);

  localparam logic [10:0]        HYST      = 11'(g_hyst);
  localparam logic [TIMER_W-1:0] MIN_ON_T  = TIMER_W'(g_min_on_s);
  localparam logic [TIMER_W-1:0] MIN_OFF_T = TIMER_W'(g_min_off_s);
  localparam logic [TIMER_W-1:0] FAN_T     = TIMER_W'(g_fan_run_s);
  localparam logic [TIMER_W-1:0] STALE_T   = TIMER_W'(g_stale_s);

  logic               tick;
  hvac_state_t        state;
  hvac_state_t        state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] stale_cnt;
  logic               first_valid;

  logic [10:0] temp_w;
  logic [10:0] sp_w;
  logic        heat_need;
  logic        cool_need;
  logic        heat_sat;
  logic        cool_sat;
  logic        enabled;
  logic        temp_known;

  sec_tick_gen #(
    .g_clk_freq(g_clk_freq)
  ) u_sec_tick_gen (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_tick (tick)
  );

  // 11-bit math keeps temp + hysteresis from wrapping near full scale.
  assign temp_w    = {1'b0, i_temp};
  assign sp_w      = {1'b0, i_setpoint};
  assign heat_need = (temp_w + HYST) <= sp_w;
  assign cool_need = temp_w >= (sp_w + HYST);
  assign heat_sat  = temp_w >= sp_w;
  assign cool_sat  = temp_w <= sp_w;

  assign enabled    = !i_sys_pwr_n && (i_mode != MODE_OFF) && !o_fault;
  assign temp_known = first_valid || i_temp_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enabled && temp_known) begin
          if (heat_need && heat_allowed(i_mode)) begin
            state_nxt = ST_HEAT;
          end else if (cool_need && cool_allowed(i_mode)) begin
            state_nxt = ST_COOL;
          end
        end
      end
      ST_HEAT: begin
        if (!enabled) begin
          state_nxt = ST_FAN_RUN;
        end else if (timer >= MIN_ON_T && (heat_sat || !heat_allowed(i_mode))) begin
          state_nxt = ST_FAN_RUN;
        end
      end
      ST_COOL: begin
        if (!enabled) begin
          state_nxt = ST_FAN_RUN;
        end else if (timer >= MIN_ON_T && (cool_sat || !cool_allowed(i_mode))) begin
          state_nxt = ST_FAN_RUN;
        end
      end
      ST_FAN_RUN: begin
        if (timer >= FAN_T) begin
          state_nxt = ST_REST;
        end
      end
      ST_REST: begin
        if (timer >= MIN_OFF_T) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      stale_cnt   <= '0;
      first_valid <= 1'b0;
      o_heat      <= 1'b0;
      o_cool      <= 1'b0;
      o_fan       <= 1'b0;
      o_fault     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state) begin
        timer <= '0;
      end else if (tick && timer != '1) begin
        timer <= timer + 1'b1;
      end

      // Outputs follow the next state so they line up with o_state.
      o_heat <= (state_nxt == ST_HEAT);
      o_cool <= (state_nxt == ST_COOL);
      o_fan  <= (state_nxt == ST_HEAT) || (state_nxt == ST_COOL) ||
                (state_nxt == ST_FAN_RUN);

      // A fresh sample always wins over a coincident tick.
      if (i_temp_valid) begin
        stale_cnt   <= '0;
        first_valid <= 1'b1;
        o_fault     <= 1'b0;
      end else if (tick) begin
        if (stale_cnt != '1) begin
          stale_cnt <= stale_cnt + 1'b1;
        end
        if (stale_cnt >= STALE_T - 1'b1) begin
          o_fault <= 1'b1;
        end
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_hvac_controller.sv
// tb/tb_hvac_controller.sv - directed self-checking bench for hvac_controller
module tb_hvac_controller;
  import thermostat_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_sys_pwr_n;
  logic [1:0] i_mode;
  logic [9:0] i_temp;
  logic       i_temp_valid;
  logic [9:0] i_setpoint;
  logic       o_heat;
  logic       o_cool;
  logic       o_fan;
  logic [2:0] o_state;
  logic       o_fault;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 i_clk = ~i_clk;

  hvac_controller #(
    .g_clk_freq (10),
    .g_hyst     (4),
    .g_min_on_s (3),
    .g_min_off_s(5),
    .g_fan_run_s(2),
    .g_stale_s  (4)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_sys_pwr_n (i_sys_pwr_n),
    .i_mode      (i_mode),
    .i_temp      (i_temp),
    .i_temp_valid(i_temp_valid),
    .i_setpoint  (i_setpoint),
    .o_heat      (o_heat),
    .o_cool      (o_cool),
    .o_fan       (o_fan),
    .o_state     (o_state),
    .o_fault     (o_fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic h,
                            input logic c, input logic f);
    check_eq({tag, "_state"}, 32'(o_state), 32'(st));
    check_eq({tag, "_heat"}, 32'(o_heat), 32'(h));
    check_eq({tag, "_cool"}, 32'(o_cool), 32'(c));
    check_eq({tag, "_fan"}, 32'(o_fan), 32'(f));
  endtask

  // Edge count since last reset release; ticks land on edges where cyc % 10 == 0.
  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic send_temp(input logic [9:0] t);
    i_temp       = t;
    i_temp_valid = 1'b1;
    step();
    i_temp_valid = 1'b0;
  endtask

  initial begin
    i_reset      = 1'b1;
    i_sys_pwr_n  = 1'b0;
    i_mode       = MODE_OFF;
    i_temp       = 10'd0;
    i_temp_valid = 1'b0;
    i_setpoint   = 10'd0;
    repeat (3) step();
    check_outs("rst", ST_IDLE, 1'b0, 1'b0, 1'b0);
    check_eq("rst_fault", 32'(o_fault), 32'd0);
    i_reset = 1'b0;
    cyc     = 0;

    // Heat cycle with minimum run time, fan overrun and rest
    i_mode     = MODE_HEAT;
    i_setpoint = 10'd280;
    i_temp     = 10'd270;
    run_to(2);
    check_outs("a_no_valid", ST_IDLE, 1'b0, 1'b0, 1'b0);
    send_temp(10'd270);
    check_outs("a_heat", ST_HEAT, 1'b1, 1'b0, 1'b1);
    run_to(12);
    send_temp(10'd280);
    check_outs("a_min_on", ST_HEAT, 1'b1, 1'b0, 1'b1);
    run_to(30);
    check_outs("a_heat_end", ST_HEAT, 1'b1, 1'b0, 1'b1);
    step();
    check_outs("a_fan", ST_FAN_RUN, 1'b0, 1'b0, 1'b1);
    run_to(45);
    send_temp(10'd280);
    run_to(50);
    check_outs("a_fan_end", ST_FAN_RUN, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("a_rest", ST_REST, 1'b0, 1'b0, 1'b0);
    run_to(65);
    send_temp(10'd280);
    run_to(85);
    send_temp(10'd280);
    run_to(100);
    check_outs("a_rest_end", ST_REST, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("a_idle", ST_IDLE, 1'b0, 1'b0, 1'b0);
    check_eq("a_fault", 32'(o_fault), 32'd0);

    // Auto mode: cool at band edge, rest completes, in-band is quiet
    i_mode = MODE_AUTO;
    send_temp(10'd284);
    check_outs("b_cool", ST_COOL, 1'b0, 1'b1, 1'b1);
    run_to(105);
    send_temp(10'd277);
    check_outs("b_min_on", ST_COOL, 1'b0, 1'b1, 1'b1);
    run_to(130);
    check_outs("b_cool_end", ST_COOL, 1'b0, 1'b1, 1'b1);
    step();
    check_outs("b_fan", ST_FAN_RUN, 1'b0, 1'b0, 1'b1);
    run_to(135);
    send_temp(10'd277);
    run_to(150);
    check_outs("b_fan_end", ST_FAN_RUN, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("b_rest", ST_REST, 1'b0, 1'b0, 1'b0);
    run_to(155);
    send_temp(10'd277);
    run_to(175);
    send_temp(10'd277);
    run_to(195);
    send_temp(10'd277);
    run_to(200);
    check_outs("b_rest_end", ST_REST, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("b_idle", ST_IDLE, 1'b0, 1'b0, 1'b0);
    send_temp(10'd282);
    check_outs("b_band", ST_IDLE, 1'b0, 1'b0, 1'b0);
    run_to(210);
    check_outs("b_band2", ST_IDLE, 1'b0, 1'b0, 1'b0);

    // Power switch off mid-heat forces fan overrun at once
    i_mode = MODE_HEAT;
    send_temp(10'd270);
    check_outs("c_heat", ST_HEAT, 1'b1, 1'b0, 1'b1);
    run_to(221);
    i_sys_pwr_n = 1'b1;
    step();
    check_outs("c_pwr_off", ST_FAN_RUN, 1'b0, 1'b0, 1'b1);
    run_to(240);
    check_outs("c_fan_end", ST_FAN_RUN, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("c_rest", ST_REST, 1'b0, 1'b0, 1'b0);
    i_sys_pwr_n = 1'b0;

    // Stale temperature fault, recovery and fault during an active call
    run_to(249);
    check_eq("d_fault_pre", 32'(o_fault), 32'd0);
    step();
    check_eq("d_fault_set", 32'(o_fault), 32'd1);
    run_to(290);
    check_outs("d_rest_end", ST_REST, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("d_idle", ST_IDLE, 1'b0, 1'b0, 1'b0);
    run_to(295);
    check_outs("d_idle_fault", ST_IDLE, 1'b0, 1'b0, 1'b0);
    send_temp(10'd270);
    check_eq("d_fault_clr", 32'(o_fault), 32'd0);
    check_outs("d_idle_clr", ST_IDLE, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("d_heat", ST_HEAT, 1'b1, 1'b0, 1'b1);
    run_to(329);
    check_eq("d_fault_pre2", 32'(o_fault), 32'd0);
    step();
    check_eq("d_fault_set2", 32'(o_fault), 32'd1);
    check_outs("d_heat_fault", ST_HEAT, 1'b1, 1'b0, 1'b1);
    step();
    check_outs("d_fault_fan", ST_FAN_RUN, 1'b0, 1'b0, 1'b1);
    run_to(340);
    send_temp(10'd270);
    check_eq("d_fault_clr2", 32'(o_fault), 32'd0);
    run_to(365);
    send_temp(10'd270);
    run_to(390);
    send_temp(10'd270);
    run_to(400);
    check_outs("d_rest_end2", ST_REST, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("d_idle2", ST_IDLE, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("d_resume", ST_HEAT, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-heat, then mid-cool
    i_reset = 1'b1;
    #1;
    check_outs("e_rst_heat", ST_IDLE, 1'b0, 1'b0, 1'b0);
    step();
    i_reset    = 1'b0;
    cyc        = 0;
    i_mode     = MODE_COOL;
    i_setpoint = 10'd280;
    run_to(2);
    send_temp(10'd290);
    check_outs("e_cool", ST_COOL, 1'b0, 1'b1, 1'b1);
    run_to(5);
    i_reset = 1'b1;
    #1;
    check_outs("e_rst_cool", ST_IDLE, 1'b0, 1'b0, 1'b0);
    check_eq("e_rst_fault", 32'(o_fault), 32'd0);
    step();
    i_reset = 1'b0;
    cyc     = 0;
    run_to(5);
    check_outs("e_no_valid", ST_IDLE, 1'b0, 1'b0, 1'b0);
    send_temp(10'd290);
    check_outs("e_cool2", ST_COOL, 1'b0, 1'b1, 1'b1);

    // Valid on the tick edge clears the stale count
    run_to(9);
    send_temp(10'd290);
    run_to(40);
    check_eq("f_clear_wins", 32'(o_fault), 32'd0);
    run_to(49);
    check_eq("f_fault_pre", 32'(o_fault), 32'd0);
    step();
    check_eq("f_fault_set", 32'(o_fault), 32'd1);
    check_outs("f_cool", ST_COOL, 1'b0, 1'b1, 1'b1);
    step();
    check_outs("f_fan", ST_FAN_RUN, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
